// File: rtl/bcd_to_bin_fsm.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional signed output enabled by defining BCD2BIN_SIGNED_EN.

module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  // Per-nibble correction after the right shift; wraps within the nibble, no carry out.
  assign dout = (din >= 4'd8) ? din - 4'd3 : din;
endmodule

module bcd_to_bin_fsm #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
`ifdef BCD2BIN_SIGNED_EN
  input  logic                  sign_in,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef BCD2BIN_SIGNED_EN
  output logic [BIN_W:0]        bin_out
`else
  output logic [BIN_W-1:0]      bin_out
`endif
);

  localparam int BCD_W = 4*DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W+1);
`ifdef BCD2BIN_SIGNED_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_shr;
  logic [SR_W-1:0]  sr_nxt;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic [DIGITS-1:0] digit_bad;
  logic             in_bad;
  logic             last_step;
  logic [OUT_W-1:0] res;

  assign sr_shr = sr >> 1;

  // BCD half sits above the binary half; bits migrate down into the binary half.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .din  (sr_shr[BIN_W + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
    assign digit_bad[g] = (bcd_in[4*g +: 4] > 4'd9);
  end

  assign sr_nxt    = {bcd_adj, sr_shr[BIN_W-1:0]};
  assign in_bad    = |digit_bad;
  assign last_step = (cnt == CNT_W'(BIN_W-1));

`ifdef BCD2BIN_SIGNED_EN
  logic           sign_q;
  logic [OUT_W-1:0] mag;
  assign mag = {1'b0, sr_nxt[BIN_W-1:0]};
  assign res = sign_q ? (~mag + 1'b1) : mag;

  always_ff @(posedge clk) begin
    if (!resetn)
      sign_q <= 1'b0;
    else if (state == S_IDLE && start && !in_bad)
      sign_q <= sign_in;
  end
`else
  assign res = sr_nxt[BIN_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
      sr      <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (in_bad) begin
              // Rejected operand: report immediately, keep the previous result.
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              sr    <= {bcd_in, {BIN_W{1'b0}}};
              cnt   <= '0;
              busy  <= 1'b1;
              err   <= 1'b0;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          sr  <= sr_nxt;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            bin_out <= res;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_fsm.sv
// Self-checking bench for bcd_to_bin_fsm: decimal reference model, per-cycle compare,
// directed cases with literal expectations, then randomized traffic.

module tb_bcd_to_bin_fsm;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
`ifdef BCD2BIN_SIGNED_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic                sign_in = 1'b0;
  logic                busy, done, err;
  logic [OUT_W-1:0]    bin_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  bcd_to_bin_fsm #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .bcd_in  (bcd_in),
`ifdef BCD2BIN_SIGNED_EN
    .sign_in (sign_in),
`endif
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal value of the operand, countdown of BIN_W steps.
  function automatic int bcd_value(input logic [4*DIGITS-1:0] b);
    int v = 0;
    for (int i = DIGITS-1; i >= 0; i--) v = v*10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit bcd_invalid(input logic [4*DIGITS-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  bit               m_busy = 0, m_done = 0, m_err = 0;
  logic [OUT_W-1:0] m_bin = '0, m_val = '0;
  int               m_rem = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_done = 0; m_err = 0; m_bin = '0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1; m_bin = m_val;
        end
      end else if (start) begin
        if (bcd_invalid(bcd_in)) begin
          m_done = 1; m_err = 1;
        end else begin
          m_val = OUT_W'(bcd_value(bcd_in));
`ifdef BCD2BIN_SIGNED_EN
          if (sign_in) m_val = OUT_W'(-bcd_value(bcd_in));
`endif
          m_busy = 1; m_rem = BIN_W; m_err = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("bin_out", 32'(bin_out), 32'(m_bin));
      if (busy && done) check("busy_done_excl", 32'(1), 32'(0));
    end
  end

  task automatic issue(input logic [15:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; bcd_in = b; sign_in = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of cycles until done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) check("done_timeout", 32'(n), 32'(0));
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] b;
    for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) b[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    return b;
  endfunction

  initial begin
    int n, pulses;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_bin", 32'(bin_out), 32'(0));
    resetn = 1'b1;
    cmp_en = 1'b1;

    // Max operand, latency
    issue(16'h9999, 1'b0);
    check("busy_after_accept", 32'(busy), 32'(1));
    wait_done(n);
    check("lat_9999", 32'(n), 32'(14));
    check("bin_9999", 32'(bin_out), 32'h270F);
    check("err_9999", 32'(err), 32'(0));

    // Back-to-back on the done cycle
    issue(16'h1234, 1'b0);
    wait_done(n);
    check("bin_1234", 32'(bin_out), 32'h04D2);
    start = 1'b1; bcd_in = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'(1));
    wait_done(n);
    check("lat_0000", 32'(n), 32'(14));
    check("bin_0000", 32'(bin_out), 32'(0));

    // Start during busy is ignored
    issue(16'h0042, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; bcd_in = 16'h9999;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("lat_0042", 32'(n + 5), 32'(14));
    check("bin_0042", 32'(bin_out), 32'd42);
    pulses = 0;
    repeat (20) begin @(negedge clk); if (done) pulses++; end
    check("single_done", 32'(pulses), 32'(0));

    // Invalid digit
    issue(16'h12A4, 1'b0);
    check("bad_done", 32'(done), 32'(1));
    check("bad_err", 32'(err), 32'(1));
    check("bad_busy", 32'(busy), 32'(0));
    check("bad_bin", 32'(bin_out), 32'd42);
    issue(16'h0007, 1'b0);
    check("err_cleared", 32'(err), 32'(0));
    wait_done(n);
    check("bin_0007", 32'(bin_out), 32'd7);

    // Reset mid-conversion
    issue(16'h0555, 1'b0);
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_bin", 32'(bin_out), 32'(0));
    resetn = 1'b1;
    pulses = 0;
    repeat (20) begin @(negedge clk); if (done) pulses++; end
    check("abort_no_done", 32'(pulses), 32'(0));

`ifdef BCD2BIN_SIGNED_EN
    issue(16'h0500, 1'b1);
    wait_done(n);
    check("neg_500", 32'(bin_out), 32'h7E0C);
    issue(16'h0000, 1'b1);
    wait_done(n);
    check("neg_zero", 32'(bin_out), 32'(0));
`endif

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 2) == 0);
      bcd_in  = rand_bcd();
      sign_in = 1'($urandom);
      resetn  = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk);
    start = 1'b0; resetn = 1'b1;
    repeat (20) @(negedge clk);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
